// File: rtl/canvas_painter_pkg.sv
// Whiteboard geometry, pen levels and painter FSM encoding
// shared by the canvas painter and its clear sweep.
package canvas_painter_pkg;

    localparam int H_CELLS = 80;
    localparam int V_CELLS = 60;
    localparam int ADDR_W  = 13;
    localparam int N_CELLS = H_CELLS * V_CELLS;
    localparam int X_W     = 7;
    localparam int Y_W     = 6;

    localparam logic PEN_DRAW  = 1'b1;
    localparam logic PEN_ERASE = 1'b0;

    typedef enum logic [1:0] {
        SWEEP = 2'd0,
        HOLD  = 2'd1,
        IDLE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           colour;
    } pen_t;

endpackage

// File: rtl/canvas_clear_sweep.sv
// Framebuffer clear sweep: walks every cell address once
// and flags the final address with a one-cycle done pulse.
module canvas_clear_sweep
    import canvas_painter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              active,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              done
);

    assign last = active && (addr == ADDR_W'(N_CELLS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr   <= '0;
            active <= 1'b1;
            done   <= 1'b0;
        end else begin
            done <= last;
            if (start) begin
                addr   <= '0;
                active <= 1'b1;
            end else if (last) begin
                addr   <= '0;
                active <= 1'b0;
            end else if (active) begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/canvas_painter.sv
// Turns cursor position and pen colour into single-pixel framebuffer
// writes; clears the whole board after reset and on request.
module canvas_painter
    import canvas_painter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [X_W-1:0]    horizontal_cursor_position,
    input  logic [Y_W-1:0]    vertical_cursor_position,
    input  logic              should_pixel_be_black_or_white,
    input  logic              is_running,
    input  logic              clear,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic              fb_wr_data,
    output logic              busy,
    output logic              clear_done
);

    state_t            state, state_nx;
    pen_t              cur, last_pen;
    logic              last_valid;
    logic              sw_start, sw_active, sw_last, sw_done;
    logic [ADDR_W-1:0] sw_addr;
    logic [ADDR_W-1:0] paint_addr;
    logic              in_range, paint_ok, paint;
    logic              wr_en_d, wr_data_d, busy_d;
    logic [ADDR_W-1:0] wr_addr_d;

    canvas_clear_sweep u_sweep (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (sw_start),
        .active  (sw_active),
        .addr    (sw_addr),
        .last    (sw_last),
        .done    (sw_done)
    );

    assign cur.x      = horizontal_cursor_position;
    assign cur.y      = vertical_cursor_position;
    assign cur.colour = should_pixel_be_black_or_white;

    // y*80 as shift-and-add
    assign paint_addr = (ADDR_W'(cur.y) << 6) + (ADDR_W'(cur.y) << 4)
                      + ADDR_W'(cur.x);

    assign in_range = (cur.x < X_W'(H_CELLS)) && (cur.y < Y_W'(V_CELLS));
    assign paint_ok = is_running && in_range
                   && (!last_valid || (cur != last_pen));

    always_comb begin
        state_nx  = state;
        sw_start  = 1'b0;
        paint     = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = fb_wr_addr;
        wr_data_d = fb_wr_data;
        busy_d    = 1'b1;
        unique case (state)
            SWEEP: begin
                wr_en_d   = sw_active;
                wr_addr_d = sw_addr;
                wr_data_d = PEN_ERASE;
                if (sw_last)
                    state_nx = clear ? HOLD : IDLE;
            end
            HOLD: begin
                if (!clear)
                    state_nx = IDLE;
            end
            IDLE: begin
                busy_d = 1'b0;
                if (clear) begin
                    state_nx = SWEEP;
                    sw_start = 1'b1;
                    busy_d   = 1'b1;
                end else if (paint_ok) begin
                    paint     = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = paint_addr;
                    wr_data_d = cur.colour;
                end
            end
            default: state_nx = SWEEP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SWEEP;
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= 1'b0;
            busy       <= 1'b1;
            clear_done <= 1'b0;
            last_valid <= 1'b0;
            last_pen   <= '0;
        end else begin
            state      <= state_nx;
            fb_wr_en   <= wr_en_d;
            fb_wr_addr <= wr_addr_d;
            fb_wr_data <= wr_data_d;
            busy       <= busy_d;
            clear_done <= sw_done;
            // the tuple is only trusted while idling
            if (state != IDLE) begin
                last_valid <= 1'b0;
            end else if (paint) begin
                last_valid <= 1'b1;
                last_pen   <= cur;
            end
        end
    end

endmodule
